axi_sram_slave: RTL and testbench

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

---
 rtl/axi_sram_slave.sv | 160 ++++++++++++++++
 tb/tb_axi_sram_slave.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slave.sv
// AXI-lite style SRAM slave: one outstanding read, one outstanding write, independent channels.
// Latency: rvalid RD_LAT cycles after AR, bvalid 2 cycles after last of AW/W; valids hold until ready.
module axi_sram_slave #(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          RD_LAT      = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] araddr_i,
    input  logic        arvalid_i,
    output logic        arready_o,
    output logic [31:0] rdata_o,
    output logic [1:0]  rresp_o,
    output logic        rvalid_o,
    input  logic        rready_i,
    input  logic [31:0] awaddr_i,
    input  logic        awvalid_i,
    output logic        awready_o,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    input  logic        wvalid_i,
    output logic        wready_o,
    output logic [1:0]  bresp_o,
    output logic        bvalid_o,
    input  logic        bready_i
);

    localparam int          IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] SPAN   = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_WAIT = 2'd1;
    localparam logic [1:0] R_RESP = 2'd2;

    localparam logic [1:0] W_IDLE   = 2'd0;
    localparam logic [1:0] W_COMMIT = 2'd1;
    localparam logic [1:0] W_RESP   = 2'd2;

    function automatic logic in_range(input logic [31:0] a);
        logic [32:0] off;
        off = {1'b0, a} - {1'b0, ADDR_BASE};
        return !off[32] && (off < SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
        return IDX_W'((a - ADDR_BASE) >> 2);
    endfunction

    logic [31:0] mem [DEPTH_WORDS];

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [31:0] ar_addr;

    logic [1:0]  w_state;
    logic        aw_got;
    logic        w_got;
    logic [31:0] aw_addr;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        mem_we;

    // Readies are gated by reset so they read 0 while reset is held.
    assign arready_o = rst_i && (r_state == R_IDLE);
    assign rvalid_o  = (r_state == R_RESP);
    assign awready_o = rst_i && (w_state == W_IDLE) && !aw_got;
    assign wready_o  = rst_i && (w_state == W_IDLE) && !w_got;
    assign bvalid_o  = (w_state == W_RESP);
    assign mem_we    = (w_state == W_COMMIT) && in_range(aw_addr);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= R_IDLE;
            r_cnt   <= '0;
            ar_addr <= '0;
            rdata_o <= '0;
            rresp_o <= OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (arvalid_i) begin
                        ar_addr <= araddr_i;
                        r_cnt   <= 4'(RD_LAT - 1);
                        r_state <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        // Nonblocking read: a commit on this same edge is not yet visible.
                        if (in_range(ar_addr)) begin
                            rdata_o <= mem[word_idx(ar_addr)];
                            rresp_o <= OKAY;
                        end else begin
                            rdata_o <= '0;
                            rresp_o <= SLVERR;
                        end
                        r_state <= R_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                R_RESP: begin
                    if (rready_i) r_state <= R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            w_state <= W_IDLE;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            aw_addr <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            bresp_o <= OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (awvalid_i && !aw_got) begin
                        aw_addr <= awaddr_i;
                        aw_got  <= 1'b1;
                    end
                    if (wvalid_i && !w_got) begin
                        w_data <= wdata_i;
                        w_strb <= wstrb_i;
                        w_got  <= 1'b1;
                    end
                    if (aw_got && w_got) w_state <= W_COMMIT;
                end
                W_COMMIT: begin
                    bresp_o <= in_range(aw_addr) ? OKAY : SLVERR;
                    w_state <= W_RESP;
                end
                W_RESP: begin
                    if (bready_i) begin
                        aw_got  <= 1'b0;
                        w_got   <= 1'b0;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_strb[b]) mem[word_idx(aw_addr)][8*b +: 8] <= w_data[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: expected responses are queued at issue time and checked by a monitor.
module tb_axi_sram_slave;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] araddr_i = '0;
    logic        arvalid_i = 1'b0;
    logic        arready_o;
    logic [31:0] rdata_o;
    logic [1:0]  rresp_o;
    logic        rvalid_o;
    logic        rready_i = 1'b1;
    logic [31:0] awaddr_i = '0;
    logic        awvalid_i = 1'b0;
    logic        awready_o;
    logic [31:0] wdata_i = '0;
    logic [3:0]  wstrb_i = '0;
    logic        wvalid_i = 1'b0;
    logic        wready_o;
    logic [1:0]  bresp_o;
    logic        bvalid_o;
    logic        bready_i = 1'b1;

    axi_sram_slave #(
        .ADDR_BASE   (32'h8000_0000),
        .DEPTH_WORDS (1024),
        .RD_LAT      (2)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .araddr_i  (araddr_i),
        .arvalid_i (arvalid_i),
        .arready_o (arready_o),
        .rdata_o   (rdata_o),
        .rresp_o   (rresp_o),
        .rvalid_o  (rvalid_o),
        .rready_i  (rready_i),
        .awaddr_i  (awaddr_i),
        .awvalid_i (awvalid_i),
        .awready_o (awready_o),
        .wdata_i   (wdata_i),
        .wstrb_i   (wstrb_i),
        .wvalid_i  (wvalid_i),
        .wready_o  (wready_o),
        .bresp_o   (bresp_o),
        .bvalid_o  (bvalid_o),
        .bready_i  (bready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    rexp_t      r_q[$];
    logic [1:0] b_q[$];
    rexp_t      mon_r;
    logic [1:0] mon_b;
    int         tests = 0;
    int         fails = 0;
    int         cyc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: handshake never happened within cycle budget", name);
    endtask

    // Monitor: the handshake completes on the next rising edge.
    always @(negedge clk_i) begin
        if (rst_i && rvalid_o && rready_i) begin
            if (r_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL r_unexpected: rvalid with rdata %h rresp %b, none expected", rdata_o, rresp_o);
            end else begin
                mon_r = r_q.pop_front();
                check("r_payload", {rdata_o, rresp_o}, {mon_r.data, mon_r.resp});
            end
        end
        if (rst_i && bvalid_o && bready_i) begin
            if (b_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL b_unexpected: bvalid with bresp %b, none expected", bresp_o);
            end else begin
                mon_b = b_q.pop_front();
                check("b_resp", bresp_o, mon_b);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic do_ar(input logic [31:0] a);
        araddr_i  = a;
        arvalid_i = 1'b1;
        for (int n = 0; ; n++) begin
            @(negedge clk_i);
            if (arready_o) break;
            if (n == 200) begin timeout("ar_hs"); break; end
        end
        @(posedge clk_i);
        #1;
        arvalid_i = 1'b0;
    endtask

    task automatic do_aw(input logic [31:0] a);
        awaddr_i  = a;
        awvalid_i = 1'b1;
        for (int n = 0; ; n++) begin
            @(negedge clk_i);
            if (awready_o) break;
            if (n == 200) begin timeout("aw_hs"); break; end
        end
        @(posedge clk_i);
        #1;
        awvalid_i = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] d, input logic [3:0] s);
        wdata_i  = d;
        wstrb_i  = s;
        wvalid_i = 1'b1;
        for (int n = 0; ; n++) begin
            @(negedge clk_i);
            if (wready_o) break;
            if (n == 200) begin timeout("w_hs"); break; end
        end
        @(posedge clk_i);
        #1;
        wvalid_i = 1'b0;
    endtask

    task automatic do_aw_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        awaddr_i  = a;
        wdata_i   = d;
        wstrb_i   = s;
        awvalid_i = 1'b1;
        wvalid_i  = 1'b1;
        for (int n = 0; ; n++) begin
            @(negedge clk_i);
            if (awready_o && wready_o) break;
            if (n == 200) begin timeout("aw_w_hs"); break; end
        end
        @(posedge clk_i);
        #1;
        awvalid_i = 1'b0;
        wvalid_i  = 1'b0;
    endtask

    task automatic wait_r(output int c);
        c = 0;
        do begin
            @(posedge clk_i);
            #1;
            c++;
        end while (!rvalid_o && c < 50);
    endtask

    task automatic wait_b(output int c);
        c = 0;
        do begin
            @(posedge clk_i);
            #1;
            c++;
        end while (!bvalid_o && c < 50);
    endtask

    task automatic write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic [1:0] exp_resp);
        int c;
        b_q.push_back(exp_resp);
        do_aw_w(a, d, s);
        wait_b(c);
        idle(1);
    endtask

    task automatic read(input logic [31:0] a, input logic [31:0] exp_data, input logic [1:0] exp_resp);
        int c;
        r_q.push_back('{data: exp_data, resp: exp_resp});
        do_ar(a);
        wait_r(c);
        idle(1);
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_rdy_vld", {arready_o, awready_o, wready_o, rvalid_o, bvalid_o}, 5'b00000);
        check("rst_rdata", rdata_o, 32'h0);
        check("rst_resps", {rresp_o, bresp_o}, 4'b0000);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check("post_rst_readies", {arready_o, awready_o, wready_o}, 3'b111);
        idle(1);

        // Same-cycle AW/W, then read-back with latency measurement.
        b_q.push_back(2'b00);
        do_aw_w(32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
        wait_b(cyc);
        check("b_latency", cyc, 2);
        idle(1);
        r_q.push_back('{data: 32'hDEAD_BEEF, resp: 2'b00});
        do_ar(32'h8000_0010);
        wait_r(cyc);
        check("r_latency", cyc, 2);
        idle(1);

        // W leads AW by three cycles, byte-lane 0 only.
        b_q.push_back(2'b00);
        do_w(32'h0000_00AA, 4'b0001);
        check("wfirst_wready", wready_o, 1'b0);
        check("wfirst_awready", awready_o, 1'b1);
        idle(2);
        do_aw(32'h8000_0010);
        wait_b(cyc);
        idle(1);
        read(32'h8000_0010, 32'hDEAD_BEAA, 2'b00);

        write(32'h8000_0010, 32'h5566_7788, 4'b1010, 2'b00);
        read(32'h8000_0010, 32'h55AD_77AA, 2'b00);

        // Range boundaries and zero strobe.
        write(32'h8000_0000, 32'hCAFE_F00D, 4'hF, 2'b00);
        read(32'h7FFF_FFFC, 32'h0, 2'b10);
        write(32'h8000_1000, 32'h1234_5678, 4'hF, 2'b10);
        read(32'h8000_0000, 32'hCAFE_F00D, 2'b00);
        read(32'h8000_1000, 32'h0, 2'b10);
        write(32'h8000_0FFC, 32'h1122_3344, 4'hF, 2'b00);
        write(32'h8000_0FFC, 32'hFFFF_FFFF, 4'h0, 2'b00);
        read(32'h8000_0FFF, 32'h1122_3344, 2'b00);

        // R channel backpressure.
        rready_i = 1'b0;
        r_q.push_back('{data: 32'h55AD_77AA, resp: 2'b00});
        do_ar(32'h8000_0010);
        wait_r(cyc);
        check("stall_latency", cyc, 2);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i);
            #1;
            check("stall_hold", {rvalid_o, arready_o, rdata_o, rresp_o}, {1'b1, 1'b0, 32'h55AD_77AA, 2'b00});
        end
        rready_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("stall_release_arready", arready_o, 1'b1);
        idle(1);

        // Reset with only AW captured: the pending write must be dropped.
        do_aw(32'h8000_0010);
        #1;
        rst_i = 1'b0;
        #1;
        check("rst_w_rdy_vld", {arready_o, awready_o, wready_o, rvalid_o, bvalid_o}, 5'b00000);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        idle(5);
        check("rst_w_no_bvalid", bvalid_o, 1'b0);
        b_q.push_back(2'b00);
        do_w(32'hFFFF_FFFF, 4'hF);
        idle(3);
        check("rst_w_wait_aw", {bvalid_o, awready_o}, 2'b01);
        do_aw(32'h8000_0020);
        wait_b(cyc);
        idle(1);
        read(32'h8000_0020, 32'hFFFF_FFFF, 2'b00);
        read(32'h8000_0010, 32'h55AD_77AA, 2'b00);

        // Reset in R_WAIT: the read must be abandoned.
        do_ar(32'h8000_0000);
        #1;
        rst_i = 1'b0;
        #1;
        check("rst_r_rdy_vld", {arready_o, awready_o, wready_o, rvalid_o, bvalid_o}, 5'b00000);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        idle(5);
        check("rst_r_no_rvalid", rvalid_o, 1'b0);
        read(32'h8000_0000, 32'hCAFE_F00D, 2'b00);

        idle(5);
        check("r_q_drained", 64'(r_q.size()), 64'd0);
        check("b_q_drained", 64'(b_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
